// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: state numbering, opcodes,
// ALUOp classes and ALU control codes.
package mc_pkg;

  localparam int unsigned NUM_STATES = 12;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/ALU_decoder.sv
// ALU operation select from the controller's ALUOp class and the instruction
// function field.
module ALU_decoder
  import mc_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALUC_AND;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALUC_ADD;
      ALUOP_SUB: ALUControl = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (Funct)
          FUNCT_ADD: ALUControl = ALUC_ADD;
          FUNCT_SUB: ALUControl = ALUC_SUB;
          FUNCT_AND: ALUControl = ALUC_AND;
          FUNCT_OR:  ALUControl = ALUC_OR;
          FUNCT_SLT: ALUControl = ALUC_SLT;
          default:   ALUControl = ALUC_AND;
        endcase
      end
      default: ALUControl = ALUC_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit: state register plus combinational
// output decode of state, opcode, Zero and the memory handshake.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               PCEn,
  output logic               illegal_op,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] state_o
);

  if (STATE_W < 4) begin : g_state_w_check
    $error("multicycle_controller: STATE_W must be at least 4");
  end

  logic [STATE_W-1:0] state_q;
  state_e             state_d;
  state_e             st;
  logic               state_valid;
  alu_op_e            alu_op;
  logic [2:0]         alu_ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= STATE_W'(FETCH);
    else        state_q <= STATE_W'(state_d);
  end

  always_comb begin
    state_valid = (state_q < STATE_W'(NUM_STATES));
    st          = state_e'(state_q[3:0]);
    state_d     = FETCH;
    alu_op      = ALUOP_ADD;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    PCEn        = 1'b0;
    illegal_op  = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    if (state_valid) begin
      case (st)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCEn    = mem_ready;
          state_d = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          case (Op)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYPE:     state_d = EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_ADDI:      state_d = ADDIEX;
            OP_J:         state_d = JUMP;
            default: begin
              state_d    = FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = (Op == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
          state_d = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          state_d  = mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          alu_op  = ALUOP_FUNCT;
          state_d = ALUWB;
        end
        ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcA = 1'b1;
          alu_op  = ALUOP_SUB;
          PCSrc   = 2'b01;
          PCEn    = Zero;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = ADDIWB;
        end
        ADDIWB: RegWrite = 1'b1;
        JUMP: begin
          PCSrc = 2'b10;
          PCEn  = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
    // Reset is synchronous, so the register may still hold an old state during
    // the first reset cycle; the outputs are masked directly instead.
    if (!rst_n) begin
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      MemRead    = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      PCEn       = 1'b0;
      illegal_op = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
    end
  end

  ALU_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .Funct      (Funct),
    .ALUControl (alu_ctrl)
  );

  assign ALUControl = (rst_n && state_valid) ? alu_ctrl : '0;
  assign state_o    = rst_n ? state_q : STATE_W'(FETCH);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle
// by cycle against hand-written expected control words.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       IorD, MemWrite, MemRead, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, PCEn, illegal_op;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Op         (Op),
    .Funct      (Funct),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .PCEn       (PCEn),
    .illegal_op (illegal_op),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUControl (ALUControl),
    .state_o    (state_o)
  );

  // {IorD,MemWrite,MemRead,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,PCEn,illegal_op,ALUSrcB,PCSrc}
  logic [13:0] outs;
  assign outs = {IorD, MemWrite, MemRead, IRWrite, RegDst, MemtoReg, RegWrite,
                 ALUSrcA, PCEn, illegal_op, ALUSrcB, PCSrc};

  function automatic logic [13:0] ow(input logic iord, mw, mr, irw, rd, m2r, rw,
                                     asa, pce, ill, input logic [1:0] asb, pcs);
    return {iord, mw, mr, irw, rd, m2r, rw, asa, pce, ill, asb, pcs};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One controller cycle: drive mem_ready, check, advance past the next edge.
  // aluc = 4'hF means ALUControl is not of interest in this state.
  task automatic cyc(input string tag, input logic mr, input logic [3:0] st,
                     input logic [13:0] e, input logic [3:0] aluc);
    mem_ready = mr;
    #1;
    check({tag, "/state"}, 32'(state_o), 32'(st));
    check({tag, "/outs"}, 32'(outs), 32'(e));
    check({tag, "/rw_excl"}, 32'(MemRead & MemWrite), 32'd0);
    if (aluc != 4'hF) check({tag, "/aluc"}, 32'(ALUControl), 32'(aluc[2:0]));
    @(posedge clk);
    #1;
  endtask

  logic [13:0] e_fetch, e_fwait, e_dec, e_ill, e_madr, e_mrd, e_mwb, e_mwr;
  logic [13:0] e_exec, e_alwb, e_brz, e_brnz, e_aiex, e_aiwb, e_jump;

  initial begin
    e_fetch = ow(0,0,1,1,0,0,0,0,1,0,2'b01,2'b00);
    e_fwait = ow(0,0,1,0,0,0,0,0,0,0,2'b01,2'b00);
    e_dec   = ow(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00);
    e_ill   = ow(0,0,0,0,0,0,0,0,0,1,2'b11,2'b00);
    e_madr  = ow(0,0,0,0,0,0,0,1,0,0,2'b10,2'b00);
    e_mrd   = ow(1,0,1,0,0,0,0,0,0,0,2'b00,2'b00);
    e_mwb   = ow(0,0,0,0,0,1,1,0,0,0,2'b00,2'b00);
    e_mwr   = ow(1,1,0,0,0,0,0,0,0,0,2'b00,2'b00);
    e_exec  = ow(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00);
    e_alwb  = ow(0,0,0,0,1,0,1,0,0,0,2'b00,2'b00);
    e_brz   = ow(0,0,0,0,0,0,0,1,1,0,2'b00,2'b01);
    e_brnz  = ow(0,0,0,0,0,0,0,1,0,0,2'b00,2'b01);
    e_aiex  = ow(0,0,0,0,0,0,0,1,0,0,2'b10,2'b00);
    e_aiwb  = ow(0,0,0,0,0,0,1,0,0,0,2'b00,2'b00);
    e_jump  = ow(0,0,0,0,0,0,0,0,1,0,2'b00,2'b10);

    rst_n = 1'b0; Op = 6'b100011; Funct = 6'b000000; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset/state", 32'(state_o), 32'd0);
    check("reset/outs", 32'(outs), 32'd0);
    check("reset/aluc", 32'(ALUControl), 32'd0);
    rst_n = 1'b1;

    // lw, memory always ready: 5 cycles
    Op = 6'b100011;
    cyc("lw_fetch", 1, 4'd0, e_fetch, 4'b0010);
    cyc("lw_dec",   1, 4'd1, e_dec,   4'b0010);
    cyc("lw_madr",  1, 4'd2, e_madr,  4'b0010);
    cyc("lw_mrd",   1, 4'd3, e_mrd,   4'hF);
    cyc("lw_mwb",   1, 4'd4, e_mwb,   4'hF);

    // sw with three wait cycles in MEMWR
    Op = 6'b101011;
    cyc("sw_fetch", 1, 4'd0, e_fetch, 4'hF);
    cyc("sw_dec",   1, 4'd1, e_dec,   4'hF);
    cyc("sw_madr",  1, 4'd2, e_madr,  4'hF);
    for (int i = 0; i < 3; i++) cyc($sformatf("sw_wait%0d", i), 0, 4'd5, e_mwr, 4'hF);
    cyc("sw_done",  1, 4'd5, e_mwr,   4'hF);
    cyc("sw_next",  0, 4'd0, e_fwait, 4'hF);

    // R-type slt then sub
    Op = 6'b000000; Funct = 6'b101010;
    cyc("slt_fetch", 1, 4'd0, e_fetch, 4'hF);
    cyc("slt_dec",   1, 4'd1, e_dec,   4'hF);
    cyc("slt_exec",  1, 4'd6, e_exec,  4'b0111);
    cyc("slt_wb",    1, 4'd7, e_alwb,  4'hF);
    Funct = 6'b100010;
    cyc("sub_fetch", 1, 4'd0, e_fetch, 4'hF);
    cyc("sub_dec",   1, 4'd1, e_dec,   4'hF);
    cyc("sub_exec",  1, 4'd6, e_exec,  4'b0110);
    cyc("sub_wb",    1, 4'd7, e_alwb,  4'hF);

    // beq taken and not taken
    Op = 6'b000100; Zero = 1'b1;
    cyc("beqt_fetch", 1, 4'd0, e_fetch, 4'hF);
    cyc("beqt_dec",   1, 4'd1, e_dec,   4'hF);
    cyc("beqt_br",    1, 4'd8, e_brz,   4'b0110);
    Zero = 1'b0;
    cyc("beqn_fetch", 1, 4'd0, e_fetch, 4'hF);
    cyc("beqn_dec",   1, 4'd1, e_dec,   4'hF);
    cyc("beqn_br",    1, 4'd8, e_brnz,  4'b0110);

    // addi
    Op = 6'b001000;
    cyc("addi_fetch", 1, 4'd0, e_fetch, 4'hF);
    cyc("addi_dec",   1, 4'd1, e_dec,   4'hF);
    cyc("addi_ex",    1, 4'd9, e_aiex,  4'b0010);
    cyc("addi_wb",    1, 4'd10, e_aiwb, 4'hF);

    // j
    Op = 6'b000010;
    cyc("j_fetch", 1, 4'd0, e_fetch, 4'hF);
    cyc("j_dec",   1, 4'd1, e_dec,   4'hF);
    cyc("j_jump",  1, 4'd11, e_jump, 4'hF);

    // illegal opcode
    Op = 6'b111111;
    cyc("ill_fetch", 1, 4'd0, e_fetch, 4'hF);
    cyc("ill_dec",   1, 4'd1, e_ill,   4'hF);
    cyc("ill_after", 0, 4'd0, e_fwait, 4'hF);

    // reset while MEMRD is waiting on memory
    Op = 6'b100011;
    cyc("rst_fetch", 1, 4'd0, e_fetch, 4'hF);
    cyc("rst_dec",   0, 4'd1, e_dec,   4'hF);
    cyc("rst_madr",  0, 4'd2, e_madr,  4'hF);
    cyc("rst_mrd",   0, 4'd3, e_mrd,   4'hF);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      check($sformatf("rst_hold%0d/state", i), 32'(state_o), 32'd0);
      check($sformatf("rst_hold%0d/outs", i), 32'(outs), 32'd0);
      check($sformatf("rst_hold%0d/aluc", i), 32'(ALUControl), 32'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    cyc("rst_rel",   0, 4'd0, e_fwait, 4'hF);
    cyc("rst_fetch2", 1, 4'd0, e_fetch, 4'hF);
    cyc("rst_dec2",  1, 4'd1, e_dec,   4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
